// File: rtl/zkbk_issue_arbiter_if.sv
// One requester channel of the Zkbk issue arbiter: request (op, operands, tag)
// plus the matching response stream, both valid/ready.
interface zkbk_issue_arbiter_if #(
    parameter int TAG_W = 4
);
    logic             req_valid;
    logic             req_ready;
    logic [3:0]       req_op;
    logic [31:0]      req_rs1;
    logic [31:0]      req_rs2;
    logic [TAG_W-1:0] req_tag;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_data;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_err;

    modport master (
        output req_valid, req_op, req_rs1, req_rs2, req_tag, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_tag, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_rs1, req_rs2, req_tag, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_tag, rsp_err
    );
endinterface

// File: rtl/zkbk_issue_arbiter.sv
// Round-robin sharing of one LATENCY-stage Zkbk unit between two requesters.
// Response appears LATENCY+1 cycles after accept; per-requester credits stall issue, never the unit.
module zkbk_issue_arbiter #(
    parameter int TAG_W      = 4,
    parameter int RESP_DEPTH = 4,
    parameter int LATENCY    = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    zkbk_issue_arbiter_if.slave ch0,
    zkbk_issue_arbiter_if.slave ch1,
    output logic [31:0]         zk_instruction,
    output logic [31:0]         zk_rs1,
    output logic [31:0]         zk_rs2,
    input  logic [31:0]         zk_out
);
    localparam int PTR_W  = $clog2(RESP_DEPTH);
    localparam int CRED_W = PTR_W + 1;
    localparam int LAST   = LATENCY - 1;

    logic [1:0] rst_sync;
    logic       rst_q_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= '0;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_q_n = rst_sync[1];

    logic [1:0]       req_valid, rsp_ready, elig, grant, push, pop, rsp_valid;
    logic [3:0]       req_op   [2];
    logic [31:0]      req_rs1  [2];
    logic [31:0]      req_rs2  [2];
    logic [TAG_W-1:0] req_tag  [2];
    logic [CRED_W-1:0] cred    [2];
    logic             rr_last;
    logic             sel;

    assign req_valid  = {ch1.req_valid, ch0.req_valid};
    assign rsp_ready  = {ch1.rsp_ready, ch0.rsp_ready};
    assign req_op[0]  = ch0.req_op;
    assign req_op[1]  = ch1.req_op;
    assign req_rs1[0] = ch0.req_rs1;
    assign req_rs1[1] = ch1.req_rs1;
    assign req_rs2[0] = ch0.req_rs2;
    assign req_rs2[1] = ch1.req_rs2;
    assign req_tag[0] = ch0.req_tag;
    assign req_tag[1] = ch1.req_tag;

    // A credit stays held until the response is popped, so an accepted op always has a FIFO slot.
    always_comb begin
        elig = '0;
        for (int i = 0; i < 2; i++) begin
            elig[i] = rst_q_n && req_valid[i] && (cred[i] < CRED_W'(RESP_DEPTH));
        end
        grant[0] = elig[0] && (!elig[1] || rr_last);
        grant[1] = elig[1] && (!elig[0] || !rr_last);
    end

    assign sel            = grant[1];
    assign zk_instruction = (|grant) ? {28'h0, req_op[sel]} : '0;
    assign zk_rs1         = (|grant) ? req_rs1[sel] : '0;
    assign zk_rs2         = (|grant) ? req_rs2[sel] : '0;
    assign ch0.req_ready  = grant[0];
    assign ch1.req_ready  = grant[1];

    // rr_last = 1 means req1 was served last, so req0 wins the next tie.
    always_ff @(posedge clk or negedge rst_q_n) begin
        if (!rst_q_n)   rr_last <= 1'b1;
        else if (|grant) rr_last <= grant[1];
    end

    logic [LATENCY-1:0] trk_vld, trk_id, trk_err;
    logic [TAG_W-1:0]   trk_tag [LATENCY];

    always_ff @(posedge clk or negedge rst_q_n) begin
        if (!rst_q_n) begin
            trk_vld <= '0;
        end else begin
            trk_vld[0] <= |grant;
            for (int s = 1; s < LATENCY; s++) trk_vld[s] <= trk_vld[s-1];
        end
    end

    always_ff @(posedge clk) begin
        trk_id[0]  <= sel;
        trk_err[0] <= (req_op[sel] >= 4'd12);
        trk_tag[0] <= req_tag[sel];
        for (int s = 1; s < LATENCY; s++) begin
            trk_id[s]  <= trk_id[s-1];
            trk_err[s] <= trk_err[s-1];
            trk_tag[s] <= trk_tag[s-1];
        end
    end

    logic [31:0] wr_data;
    assign push[0] = trk_vld[LAST] && !trk_id[LAST];
    assign push[1] = trk_vld[LAST] &&  trk_id[LAST];
    assign wr_data = trk_err[LAST] ? '0 : zk_out;

    logic [PTR_W:0]          wptr     [2];
    logic [PTR_W:0]          rptr     [2];
    logic [31:0]             mem_data [2][RESP_DEPTH];
    logic [TAG_W-1:0]        mem_tag  [2][RESP_DEPTH];
    logic [RESP_DEPTH-1:0]   mem_err  [2];
    logic [31:0]             rsp_data [2];
    logic [TAG_W-1:0]        rsp_tag  [2];
    logic [1:0]              rsp_err;

    always_comb begin
        rsp_valid = '0;
        pop       = '0;
        rsp_err   = '0;
        for (int i = 0; i < 2; i++) begin
            rsp_valid[i] = (wptr[i] != rptr[i]);
            pop[i]       = rsp_valid[i] && rsp_ready[i];
            rsp_data[i]  = rsp_valid[i] ? mem_data[i][rptr[i][PTR_W-1:0]] : '0;
            rsp_tag[i]   = rsp_valid[i] ? mem_tag[i][rptr[i][PTR_W-1:0]] : '0;
            rsp_err[i]   = rsp_valid[i] && mem_err[i][rptr[i][PTR_W-1:0]];
        end
    end

    always_ff @(posedge clk or negedge rst_q_n) begin
        if (!rst_q_n) begin
            for (int i = 0; i < 2; i++) begin
                wptr[i] <= '0;
                rptr[i] <= '0;
                cred[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (push[i]) wptr[i] <= wptr[i] + 1'b1;
                if (pop[i])  rptr[i] <= rptr[i] + 1'b1;
                cred[i] <= cred[i] + CRED_W'(grant[i]) - CRED_W'(pop[i]);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (push[i]) begin
                mem_data[i][wptr[i][PTR_W-1:0]] <= wr_data;
                mem_tag[i][wptr[i][PTR_W-1:0]]  <= trk_tag[LAST];
                mem_err[i][wptr[i][PTR_W-1:0]]  <= trk_err[LAST];
            end
        end
    end

    assign ch0.rsp_valid = rsp_valid[0];
    assign ch1.rsp_valid = rsp_valid[1];
    assign ch0.rsp_data  = rsp_data[0];
    assign ch1.rsp_data  = rsp_data[1];
    assign ch0.rsp_tag   = rsp_tag[0];
    assign ch1.rsp_tag   = rsp_tag[1];
    assign ch0.rsp_err   = rsp_err[0];
    assign ch1.rsp_err   = rsp_err[1];
endmodule

// File: tb/tb_zkbk_issue_arbiter.sv
// Bench for zkbk_issue_arbiter: behavioural two-stage Zkbk unit, queue-driven
// requesters and per-requester expected-response scoreboards.
module tb_zkbk_issue_arbiter;
    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  tag;
    } stim_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  tag;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] zk_instruction, zk_rs1, zk_rs2;
    logic [31:0] zk_out = 32'hDEAD_BEEF;
    logic [31:0] u_ins = 32'hFFFF_FFFF, u_a = 32'h1234_5678, u_b = 32'h9ABC_DEF0;

    zkbk_issue_arbiter_if #(.TAG_W(4)) p0 ();
    zkbk_issue_arbiter_if #(.TAG_W(4)) p1 ();

    zkbk_issue_arbiter #(.TAG_W(4), .RESP_DEPTH(4), .LATENCY(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ch0            (p0),
        .ch1            (p1),
        .zk_instruction (zk_instruction),
        .zk_rs1         (zk_rs1),
        .zk_rs2         (zk_rs2),
        .zk_out         (zk_out)
    );

    always #5 clk = ~clk;

    int    n_tests = 0, n_fail = 0;
    int    cyc = 0;
    int    n_acc0 = 0, n_acc1 = 0, n_rsp0 = 0, n_rsp1 = 0, acc_cyc0 = 0;
    stim_t stim0[$], stim1[$];
    exp_t  exp0[$], exp1[$];
    int    gseq[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] zk_ref(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic [4:0]  s;
        s = b[4:0];
        r = '0;
        case (ins)
            32'd0, 32'd2: r = (a >> s) | (a << (6'd32 - {1'b0, s}));
            32'd1:        r = (a << s) | (a >> (6'd32 - {1'b0, s}));
            32'd3:        r = a & ~b;
            32'd4:        r = a | ~b;
            32'd5:        r = ~(a ^ b);
            32'd6:        r = {b[15:0], a[15:0]};
            32'd7:        r = {16'h0, b[7:0], a[7:0]};
            32'd8:        for (int i = 0; i < 32; i++) r[i] = a[(i & ~7) | (7 - (i & 7))];
            32'd9:        r = {a[7:0], a[15:8], a[23:16], a[31:24]};
            32'd10:       for (int i = 0; i < 16; i++) begin r[2*i] = a[i]; r[2*i+1] = a[i+16]; end
            32'd11:       for (int i = 0; i < 16; i++) begin r[i] = a[2*i]; r[i+16] = a[2*i+1]; end
            default:      r = 32'hBAD0_0000 | {16'h0, ins[15:0]};
        endcase
        return r;
    endfunction

    function automatic exp_t mk_exp(input stim_t s);
        exp_t e;
        e.err  = (s.op >= 4'd12);
        e.data = e.err ? 32'h0 : zk_ref({28'h0, s.op}, s.a, s.b);
        e.tag  = s.tag;
        return e;
    endfunction

    // Unit model: inputs registered, result registered; no reset on purpose.
    always @(posedge clk) begin
        u_ins  <= zk_instruction;
        u_a    <= zk_rs1;
        u_b    <= zk_rs2;
        zk_out <= zk_ref(u_ins, u_a, u_b);
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        p0.req_valid = 1'b0; p0.req_op = '0; p0.req_rs1 = '0; p0.req_rs2 = '0; p0.req_tag = '0;
        p1.req_valid = 1'b0; p1.req_op = '0; p1.req_rs1 = '0; p1.req_rs2 = '0; p1.req_tag = '0;
        forever begin
            @(posedge clk);
            #1;
            p0.req_valid = (stim0.size() > 0);
            if (stim0.size() > 0) {p0.req_op, p0.req_rs1, p0.req_rs2, p0.req_tag} = stim0[0];
            p1.req_valid = (stim1.size() > 0);
            if (stim1.size() > 0) {p1.req_op, p1.req_rs1, p1.req_rs2, p1.req_tag} = stim1[0];
        end
    end

    // Scoreboard: push on accept, pop/compare on response handshake.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (p0.req_valid && p0.req_ready && stim0.size() > 0) begin
            exp0.push_back(mk_exp(stim0[0]));
            void'(stim0.pop_front());
            n_acc0++;
            acc_cyc0 = cyc;
            gseq.push_back(0);
        end
        if (p1.req_valid && p1.req_ready && stim1.size() > 0) begin
            exp1.push_back(mk_exp(stim1[0]));
            void'(stim1.pop_front());
            n_acc1++;
            gseq.push_back(1);
        end
        if (p0.rsp_valid && p0.rsp_ready) begin
            n_rsp0++;
            check("rsp0_pending", exp0.size() != 0, 1);
            if (exp0.size() != 0) begin
                e = exp0.pop_front();
                check("rsp0_data", p0.rsp_data, e.data);
                check("rsp0_tag", p0.rsp_tag, e.tag);
                check("rsp0_err", p0.rsp_err, e.err);
            end
        end
        if (p1.rsp_valid && p1.rsp_ready) begin
            n_rsp1++;
            check("rsp1_pending", exp1.size() != 0, 1);
            if (exp1.size() != 0) begin
                e = exp1.pop_front();
                check("rsp1_data", p1.rsp_data, e.data);
                check("rsp1_tag", p1.rsp_tag, e.tag);
                check("rsp1_err", p1.rsp_err, e.err);
            end
        end
    end

    task automatic drain(input string nm);
        int k = 0;
        while ((stim0.size() + stim1.size() + exp0.size() + exp1.size()) != 0 && k < 300) begin
            @(posedge clk);
            k++;
        end
        check(nm, stim0.size() + stim1.size() + exp0.size() + exp1.size(), 0);
        repeat (2) @(posedge clk);
    endtask

    task automatic push_at_negedge();
        @(negedge clk);
        #2;
    endtask

    initial begin
        int k, t_acc, a0, a1, r0, t_res;
        p0.rsp_ready = 1'b1;
        p1.rsp_ready = 1'b1;
        stim0.push_back('{op: 4'd0, a: 32'h8000_0001, b: 32'd1, tag: 4'd5});

        // Reset state with a request already waiting
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready0", p0.req_ready, 0);
        check("rst_rsp0_valid", p0.rsp_valid, 0);
        check("rst_rsp1_valid", p1.rsp_valid, 0);
        check("rst_zk", {zk_instruction, zk_rs1[15:0], zk_rs2[15:0]}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Test 1: ror, latency
        k = 0;
        while (n_acc0 < 1 && k < 30) begin @(negedge clk); k++; end
        t_acc = acc_cyc0;
        k = 0;
        while (!p0.rsp_valid && k < 10) begin @(negedge clk); k++; end
        check("t1_latency", cyc - t_acc, 3);
        check("t1_data", p0.rsp_data, 32'hC000_0000);
        check("t1_tag", p0.rsp_tag, 4'd5);
        drain("t1_drain");
        check("idle_zk", {zk_instruction, zk_rs1, zk_rs2}, 0);

        // Test 2: both requesters saturated, grants alternate
        push_at_negedge();
        gseq.delete();
        for (int i = 0; i < 8; i++) begin
            stim0.push_back('{op: 4'd3, a: 32'hFFFF_00FF, b: 32'h0F0F_0F0F, tag: 4'(i)});
            stim1.push_back('{op: 4'd3, a: 32'hFFFF_00FF, b: 32'h0F0F_0F0F, tag: 4'(i + 8)});
        end
        drain("t2_drain");
        check("t2_grants", gseq.size(), 16);
        for (int i = 0; i < gseq.size() && i < 16; i++) check("t2_alt", gseq[i], (i + 1) % 2);

        // Tests 3/4: req0 backpressured to credit limit, then released
        @(posedge clk); #1;
        p0.rsp_ready = 1'b0;
        push_at_negedge();
        a0 = n_acc0; a1 = n_acc1; r0 = n_rsp0;
        for (int i = 0; i < 10; i++)
            stim0.push_back('{op: 4'd5, a: 32'h0101_0101 * i, b: 32'h00FF_00FF, tag: 4'(i)});
        for (int i = 0; i < 4; i++)
            stim1.push_back('{op: 4'd10, a: 32'hFFFF_0000 ^ i, b: 32'h0, tag: 4'(i)});
        repeat (14) @(posedge clk);
        @(negedge clk);
        check("t3_acc0_limit", n_acc0 - a0, 4);
        check("t3_ready0_low", p0.req_ready, 0);
        check("t3_rsp0_valid", p0.rsp_valid, 1);
        check("t3_acc1", n_acc1 - a1, 4);
        check("t3_rsp1_done", exp1.size(), 0);
        @(posedge clk); #1;
        p0.rsp_ready = 1'b1;
        @(negedge clk);
        check("t3_ready0_pop_cycle", p0.req_ready, 0);
        @(negedge clk);
        check("t3_ready0_resume", p0.req_ready, 1);
        t_res = cyc;
        drain("t3_drain");
        check("t4_acc0_total", n_acc0 - a0, 10);
        check("t4_rsp0_total", n_rsp0 - r0, 10);
        check("t4_back_to_back", acc_cyc0 - t_res, 5);

        // Test 5: illegal opcodes
        push_at_negedge();
        stim1.push_back('{op: 4'd12, a: 32'h0000_1234, b: 32'h0000_5678, tag: 4'd1});
        stim1.push_back('{op: 4'd15, a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF, tag: 4'd2});
        stim1.push_back('{op: 4'd9,  a: 32'h1122_3344, b: 32'h0, tag: 4'd3});
        drain("t5_drain");

        // Test 6: reset with ops in flight
        push_at_negedge();
        a0 = n_acc0;
        stim0.push_back('{op: 4'd4, a: 32'h0F00_F00F, b: 32'h00FF_FF00, tag: 4'd7});
        stim0.push_back('{op: 4'd8, a: 32'h0102_0480, b: 32'h0, tag: 4'd8});
        k = 0;
        while (n_acc0 - a0 < 2 && k < 20) begin @(negedge clk); k++; end
        check("t6_issued", n_acc0 - a0, 2);
        @(posedge clk); #2;
        rst_n = 1'b0;
        exp0.delete();
        exp1.delete();
        stim0.push_back('{op: 4'd1, a: 32'h8000_0001, b: 32'd4, tag: 4'd9});
        #1;
        check("t6_rsp0_valid", p0.rsp_valid, 0);
        check("t6_rsp0_data", {p0.rsp_data, p0.rsp_tag, p0.rsp_err}, 0);
        check("t6_zk", {zk_instruction, zk_rs1, zk_rs2}, 0);
        @(posedge clk);
        @(negedge clk);
        check("t6_ready0_rst", p0.req_ready, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        drain("t6_after_drain");

        // Credits restart from zero after reset
        @(posedge clk); #1;
        p0.rsp_ready = 1'b0;
        push_at_negedge();
        a0 = n_acc0;
        for (int i = 0; i < 5; i++)
            stim0.push_back('{op: 4'd11, a: 32'hA5A5_0F0F + i, b: 32'h0, tag: 4'(i)});
        repeat (12) @(posedge clk);
        @(negedge clk);
        check("t6_cred_limit", n_acc0 - a0, 4);
        @(posedge clk); #1;
        p0.rsp_ready = 1'b1;
        drain("t6_cred_drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end
endmodule
